// File: rtl/rvc_asap_5pl_mem_arb.sv
// Two-master arbiter sharing the mem_wrap data port between the core (M0) and a loader/DMA (M1).
// Optional grant/stall statistics counters are enabled with `define MEM_ARB_STATS_EN.
module rvc_asap_5pl_mem_arb #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BURST_MAX    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic        m0_wr_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wr_data_i,
  input  logic [3:0]  m0_byte_en_i,
  input  logic        m1_req_i,
  input  logic        m1_wr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wr_data_i,
  input  logic [3:0]  m1_byte_en_i,
  input  logic        m1_lock_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  output logic        m0_stall_o,
  output logic        m0_rd_valid_o,
  output logic        m1_rd_valid_o,
  output logic [31:0] m0_rd_data_o,
  output logic [31:0] m1_rd_data_o,
  output logic [31:0] data_o,
  output logic [31:0] address_o,
  output logic [3:0]  byteena_o,
  output logic        wren_o,
  output logic        rden_o,
  input  logic [31:0] q_i
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] m0_gnt_cnt_o,
  output logic [31:0] m1_gnt_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int unsigned SCW = 4;
  localparam int unsigned BCW = 8;

  typedef enum logic {
    ST_ARB,
    ST_M1_BURST
  } state_e;

  state_e         state_q, state_d;
  logic [SCW-1:0] starve_q, starve_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [BCW-1:0] beat_inc;
  logic           relock_blk_q, relock_blk_d;
  logic           m0_rd_own_q, m0_rd_own_d;
  logic           m1_rd_own_q, m1_rd_own_d;
  logic           m0_gnt;
  logic           m1_gnt;

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      starve_q     <= '0;
      beat_q       <= '0;
      relock_blk_q <= 1'b0;
      m0_rd_own_q  <= 1'b0;
      m1_rd_own_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      beat_q       <= beat_d;
      relock_blk_q <= relock_blk_d;
      m0_rd_own_q  <= m0_rd_own_d;
      m1_rd_own_q  <= m1_rd_own_d;
    end
  end

  // Grant decision, burst tracking and starvation counter
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    beat_d       = beat_q;
    relock_blk_d = 1'b0;
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    beat_inc     = beat_q + BCW'(1);

    if (rst_n) begin
      case (state_q)
        ST_ARB: begin
          if (m0_req_i && !(m1_req_i && (starve_q == SCW'(STARVE_LIMIT)))) begin
            m0_gnt = 1'b1;
          end else if (m1_req_i) begin
            m1_gnt = 1'b1;
          end
          // A forced release leaves exactly one ARB cycle where the lock is ignored
          if (m1_gnt && m1_lock_i && !relock_blk_q) begin
            beat_d = BCW'(1);
            if (BURST_MAX == 1) begin
              relock_blk_d = 1'b1;
            end else begin
              state_d = ST_M1_BURST;
            end
          end
        end
        ST_M1_BURST: begin
          m1_gnt = m1_req_i;
          if (!m1_lock_i) begin
            state_d = ST_ARB;
          end else if (m1_gnt) begin
            beat_d = beat_inc;
            if (beat_inc == BCW'(BURST_MAX)) begin
              state_d      = ST_ARB;
              relock_blk_d = 1'b1;
            end
          end
        end
        default: state_d = ST_ARB;
      endcase

      if (m1_gnt) begin
        starve_d = '0;
      end else if (m1_req_i && (starve_q != SCW'(STARVE_LIMIT))) begin
        starve_d = starve_q + SCW'(1);
      end
    end
  end

  // Port mux; idle port drives zeros
  always_comb begin
    address_o = '0;
    data_o    = '0;
    byteena_o = '0;
    if (m0_gnt) begin
      address_o = m0_addr_i;
      data_o    = m0_wr_data_i;
      byteena_o = m0_byte_en_i;
    end else if (m1_gnt) begin
      address_o = m1_addr_i;
      data_o    = m1_wr_data_i;
      byteena_o = m1_byte_en_i;
    end
  end

  assign m0_gnt_o   = m0_gnt;
  assign m1_gnt_o   = m1_gnt;
  assign m0_stall_o = m0_req_i & ~m0_gnt;
  assign wren_o     = (m0_gnt & m0_wr_i) | (m1_gnt & m1_wr_i);
  assign rden_o     = (m0_gnt & ~m0_wr_i) | (m1_gnt & ~m1_wr_i);

  // Read data returns one cycle after the grant to whoever issued the read
  assign m0_rd_own_d   = m0_gnt & ~m0_wr_i;
  assign m1_rd_own_d   = m1_gnt & ~m1_wr_i;
  assign m0_rd_valid_o = m0_rd_own_q;
  assign m1_rd_valid_o = m1_rd_own_q;
  assign m0_rd_data_o  = m0_rd_own_q ? q_i : '0;
  assign m1_rd_data_o  = m1_rd_own_q ? q_i : '0;

`ifdef MEM_ARB_STATS_EN
  localparam int unsigned CW = 32;

  logic [CW-1:0] m0_gnt_cnt_q, m1_gnt_cnt_q, stall_cnt_q;

  // Saturating grant and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_gnt_cnt_q <= '0;
      m1_gnt_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (m0_gnt && (m0_gnt_cnt_q != '1)) m0_gnt_cnt_q <= m0_gnt_cnt_q + CW'(1);
      if (m1_gnt && (m1_gnt_cnt_q != '1)) m1_gnt_cnt_q <= m1_gnt_cnt_q + CW'(1);
      if (m0_stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CW'(1);
    end
  end

  assign m0_gnt_cnt_o = m0_gnt_cnt_q;
  assign m1_gnt_cnt_o = m1_gnt_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule
